// File: rtl/mips_pkg.sv
// Shared definitions for the fetch-stage slice.
//   fetch_state_t    : fetch FSM encoding (IDLE / FETCH / DROP)
//   WORD_W           : datapath / address width
//   RESET_PC_DEFAULT : default PC loaded on reset
package mips_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ack bus between the fetch stage and memory.
//   imem_req   : request, held until imem_ack
//   imem_addr  : registered request address, stable while imem_req=1
//   imem_ack   : one-cycle completion pulse
//   imem_rdata : instruction word, valid with imem_ack
// master = fetch stage, slave = instruction memory.
interface fetch_stage_if;
  import mips_pkg::*;

  logic              imem_req;
  logic [WORD_W-1:0] imem_addr;
  logic              imem_ack;
  logic [WORD_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/Adder.sv
// Combinational WIDTH-bit adder, result modulo 2^WIDTH.
//   a, b : operands
//   sum  : a + b (carry out discarded)
module Adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  always_comb begin
    sum = a + b;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with a single-entry fetch buffer.
//   clk, rst   : clock and synchronous active-high reset
//   freeze     : ID stall, the buffer is not consumed this cycle
//   Br_taken   : one-cycle branch redirect from EXE
//   Br_Addr    : branch target, valid with Br_taken
//   imem       : instruction-memory bus (master side)
//   IF_PC      : PC+4 of the buffered instruction
//   IF_instr   : buffered instruction word
//   IF_valid   : buffer holds an unconsumed instruction
//   flush      : combinational IF/ID flush (Br_taken, masked by rst)
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              Br_taken,
  input  logic [WORD_W-1:0] Br_Addr,
  fetch_stage_if.master     imem,
  output logic [WORD_W-1:0] IF_PC,
  output logic [WORD_W-1:0] IF_instr,
  output logic              IF_valid,
  output logic              flush
);

  fetch_state_t      state, state_next;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] pc_plus4;
  logic [WORD_W-1:0] addr_q;
  logic              consume;
  logic              start_fetch;
  logic              fill;

  Adder #(
    .WIDTH(WORD_W)
  ) u_pc_adder (
    .a  (pc),
    .b  (WORD_W'(4)),
    .sum(pc_plus4)
  );

  assign consume = IF_valid & ~freeze;

  // A new request only starts when the buffer will be empty next cycle,
  // so the buffer is guaranteed empty for the whole FETCH.
  assign start_fetch = (state == IDLE) && !Br_taken && (!IF_valid || !freeze);

  // Returned data is kept only in FETCH and only without a redirect.
  assign fill = (state == FETCH) && imem.imem_ack && !Br_taken;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start_fetch) state_next = FETCH;
      end
      FETCH: begin
        if (imem.imem_ack)  state_next = IDLE;
        else if (Br_taken)  state_next = DROP;
      end
      DROP: begin
        if (imem.imem_ack)  state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    imem.imem_req  = (state != IDLE);
    imem.imem_addr = addr_q;
    flush          = Br_taken & ~rst;
  end

  // Datapath: PC, request address and fetch buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      addr_q   <= '0;
      IF_PC    <= '0;
      IF_instr <= '0;
      IF_valid <= 1'b0;
    end else begin
      if (start_fetch) begin
        addr_q <= pc;
      end

      if (Br_taken) begin
        pc       <= Br_Addr;
        IF_valid <= 1'b0;
      end else if (fill) begin
        pc       <= pc_plus4;
        IF_PC    <= pc_plus4;
        IF_instr <= imem.imem_rdata;
        IF_valid <= 1'b1;
      end else if (consume) begin
        IF_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import mips_pkg::*;

  logic              clk;
  logic              rst;
  logic              freeze;
  logic              Br_taken;
  logic [WORD_W-1:0] Br_Addr;
  logic [WORD_W-1:0] IF_PC;
  logic [WORD_W-1:0] IF_instr;
  logic              IF_valid;
  logic              flush;

  int unsigned tests;
  int unsigned fails;

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .freeze  (freeze),
    .Br_taken(Br_taken),
    .Br_Addr (Br_Addr),
    .imem    (bus.master),
    .IF_PC   (IF_PC),
    .IF_instr(IF_instr),
    .IF_valid(IF_valid),
    .flush   (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    tests          = 0;
    fails          = 0;
    rst            = 1'b1;
    freeze         = 1'b0;
    Br_taken       = 1'b1;
    Br_Addr        = 32'h0000_0abc;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;

    // Reset state; flush masked while rst=1 even with Br_taken
    tick();
    tick();
    chk("rst_flush",    {31'd0, flush},         32'd0);
    Br_taken = 1'b0;
    #1;
    chk("rst_req",      {31'd0, bus.imem_req},  32'd0);
    chk("rst_addr",     bus.imem_addr,          32'd0);
    chk("rst_valid",    {31'd0, IF_valid},      32'd0);
    chk("rst_ifpc",     IF_PC,                  32'd0);
    chk("rst_instr",    IF_instr,               32'd0);

    // First request at RESET_PC on the first IDLE cycle after reset
    rst = 1'b0;
    tick();
    chk("f0_req",  {31'd0, bus.imem_req}, 32'd1);
    chk("f0_addr", bus.imem_addr,         32'h0);
    tick();
    chk("f0_hold_addr", bus.imem_addr, 32'h0);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h2001_0005;
    tick();
    bus.imem_ack = 1'b0;
    chk("f0_valid", {31'd0, IF_valid},      32'd1);
    chk("f0_ifpc",  IF_PC,                  32'h4);
    chk("f0_instr", IF_instr,               32'h2001_0005);
    chk("f0_idle",  {31'd0, bus.imem_req},  32'd0);

    // Buffer consumed, next request to 4
    tick();
    chk("f1_addr",  bus.imem_addr,     32'h4);
    chk("f1_valid", {31'd0, IF_valid}, 32'd0);
    tick();
    bus.imem_ack = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    chk("f1_ifpc", IF_PC, 32'h8);

    // Freeze with a full buffer: no new request, buffer holds
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_req",   {31'd0, bus.imem_req}, 32'd0);
      chk("frz_valid", {31'd0, IF_valid},     32'd1);
      chk("frz_ifpc",  IF_PC,                 32'h8);
      chk("frz_instr", IF_instr,              32'h2001_0005);
    end
    freeze = 1'b0;
    tick();
    chk("f2_req",  {31'd0, bus.imem_req}, 32'd1);
    chk("f2_addr", bus.imem_addr,         32'h8);

    // Branch in FETCH before ack: DROP, data discarded, refetch at target
    tick();
    Br_taken = 1'b1; Br_Addr = 32'h40;
    #1;
    chk("drop_flush", {31'd0, flush}, 32'd1);
    tick();
    Br_taken = 1'b0;
    chk("drop_req",  {31'd0, bus.imem_req}, 32'd1);
    chk("drop_addr", bus.imem_addr,         32'h8);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hdead_beef;
    tick();
    bus.imem_ack = 1'b0;
    chk("drop_valid", {31'd0, IF_valid},     32'd0);
    chk("drop_idle",  {31'd0, bus.imem_req}, 32'd0);
    tick();
    chk("br_addr", bus.imem_addr,     32'h40);
    chk("br_valid", {31'd0, IF_valid}, 32'd0);

    // Branch together with ack: discard, straight to IDLE
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1234_5678;
    Br_taken = 1'b1; Br_Addr = 32'h100;
    tick();
    bus.imem_ack = 1'b0; Br_taken = 1'b0;
    chk("brack_valid", {31'd0, IF_valid},     32'd0);
    chk("brack_nodrop", {31'd0, bus.imem_req}, 32'd0);
    tick();
    chk("brack_addr", bus.imem_addr, 32'h100);

    // Branch while frozen with a full buffer
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1111_2222; freeze = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    chk("bf_valid1", {31'd0, IF_valid}, 32'd1);
    chk("bf_ifpc",   IF_PC,             32'h104);
    tick();
    chk("bf_hold", {31'd0, IF_valid}, 32'd1);
    Br_taken = 1'b1; Br_Addr = 32'h200;
    #1;
    chk("bf_flush", {31'd0, flush}, 32'd1);
    tick();
    Br_taken = 1'b0;
    chk("bf_valid0", {31'd0, IF_valid},     32'd0);
    chk("bf_blocked", {31'd0, bus.imem_req}, 32'd0);
    tick();
    chk("bf_addr", bus.imem_addr, 32'h200);
    freeze = 1'b0;

    // Reset mid-FETCH, stray ack on the first IDLE cycle afterwards
    tick();
    rst = 1'b1;
    tick();
    chk("mrst_req",   {31'd0, bus.imem_req}, 32'd0);
    chk("mrst_valid", {31'd0, IF_valid},     32'd0);
    rst = 1'b0; bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0bad_0bad;
    tick();
    bus.imem_ack = 1'b0;
    chk("stray_valid", {31'd0, IF_valid},     32'd0);
    chk("stray_req",   {31'd0, bus.imem_req}, 32'd1);
    chk("stray_addr",  bus.imem_addr,         32'h0);
    tick();
    chk("stray_still_fetch", {31'd0, bus.imem_req}, 32'd1);
    chk("stray_valid2", {31'd0, IF_valid},          32'd0);

    // PC wrap: branch to FFFF_FFFC, fetch there, IF_PC wraps to 0
    Br_taken = 1'b1; Br_Addr = 32'hffff_fffc;
    tick();
    Br_taken = 1'b0;
    bus.imem_ack = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    tick();
    chk("wrap_addr", bus.imem_addr, 32'hffff_fffc);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hcafe_f00d;
    freeze = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    chk("wrap_ifpc",  IF_PC,    32'h0);
    chk("wrap_instr", IF_instr, 32'hcafe_f00d);
    freeze = 1'b0;
    tick();
    chk("wrap_next", bus.imem_addr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous and active-high.
REQ-004 freeze  input  1  SHALL be the hazard-unit stall: the ID stage does not consume the fetch buffer this cycle.
REQ-005 Br_taken  input  1  SHALL be the one-cycle branch-redirect pulse from the EXE stage.
REQ-006 Br_Addr  input  32  SHALL be the branch target, valid when Br_taken=1.
REQ-007 imem_req  output  1  SHALL be the instruction-memory request.
REQ-008 imem_addr  output  32  SHALL be the registered request address.
REQ-009 imem_ack  input  1  SHALL be a one-cycle memory completion pulse.
REQ-010 imem_rdata  input  32  SHALL be the instruction word, valid when imem_ack=1.
REQ-011 IF_PC  output  32  SHALL be PC+4 of the buffered instruction.
REQ-012 IF_instr  output  32  SHALL be the buffered instruction word.
REQ-013 IF_valid  output  1  SHALL be high while the fetch buffer holds an unconsumed instruction.
REQ-014 flush  output  1  SHALL be the combinational IF/ID flush, equal to Br_taken and forced to 0 while rst=1.

Function
REQ-015 FSM states SHALL be IDLE (imem_req=0), FETCH (imem_req=1) and DROP (imem_req=1, returned data discarded).
REQ-016 The buffer SHALL be consumed in any cycle with IF_valid=1 and freeze=0; IF_valid then clears next cycle unless it is refilled.
REQ-017 IDLE->FETCH SHALL occur when Br_taken=0 and (IF_valid=0 or freeze=0); on that transition imem_addr<=PC. The buffer is therefore always empty during FETCH.
REQ-018 imem_req, once asserted, SHALL stay high with imem_addr stable until the cycle of imem_ack.
REQ-019 FETCH with imem_ack=1 and Br_taken=0 SHALL load IF_instr<=imem_rdata, IF_PC<=PC+4, IF_valid<=1 and PC<=PC+4, then go to IDLE. Fetch latency is memory latency plus 1 cycle.
REQ-020 Br_taken=1 in any state SHALL set PC<=Br_Addr and IF_valid<=0; Br_taken has priority over freeze and over imem_ack.
REQ-021 Br_taken=1 in FETCH without imem_ack SHALL move to DROP; with imem_ack in the same cycle, the data SHALL be discarded and the FSM SHALL go to IDLE.
REQ-022 DROP SHALL hold the request until imem_ack, discard imem_rdata, then go to IDLE; a further Br_taken in DROP only updates PC.
REQ-023 Br_taken in IDLE SHALL block the IDLE->FETCH transition that cycle, so the next fetch uses Br_Addr.
REQ-024 imem_ack received in IDLE SHALL be ignored.
REQ-025 PC arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.

Reset
REQ-026 Reset SHALL give: state IDLE, PC=RESET_PC, imem_req=0, imem_addr=0, IF_PC=0, IF_instr=0, IF_valid=0, flush=0.
REQ-027 Reset asserted mid-FETCH or mid-DROP SHALL abandon the transaction; a late imem_ack after reset is covered by REQ-024.
REQ-028 The first request SHALL issue to RESET_PC on the first IDLE cycle after rst deasserts.

Structure
REQ-029 Shared package mips_pkg SHALL hold the FSM state encoding, the WORD_W=32 constant and the RESET_PC default.
REQ-030 The PC+4 incrementer SHALL be one instance of the existing Adder sub-module; everything else stays inline.

Verification
REQ-031 Reset, then imem_ack 2 cycles after each req with rdata=32'h2001_0005 and freeze=0 -> imem_addr sequence 0, 4, 8; IF_PC=4 with IF_instr=32'h2001_0005.
REQ-032 Buffer valid (IF_PC=8) while freeze=1 for 3 cycles -> imem_req stays 0 and IF_valid, IF_PC and IF_instr hold; freeze drops -> request to addr 8 next cycle.
REQ-033 Br_taken=1 with Br_Addr=32'h40 in FETCH before ack -> flush=1 that cycle and FSM enters DROP; the acked data is discarded (IF_valid stays 0); next request addr=32'h40.
REQ-034 Br_taken in the same cycle as imem_ack -> IF_valid stays 0, PC=Br_Addr, no DROP state.
REQ-035 Br_taken with freeze=1 and IF_valid=1 -> IF_valid=0 next cycle and flush=1 during the pulse.
REQ-036 rst pulsed during FETCH, then a stray imem_ack in IDLE -> IF_valid stays 0; next request addr=RESET_PC.
